// File: rtl/unidade_controlo.sv
// Control unit of the LSDi 8-bit teaching processor: PC, instruction register,
// register file, accumulator, zero flag and I/O ports, sequenced FETCH/EXECUTE.
module unidade_controlo (
  input  logic       clock,
  input  logic       reset,
  input  logic       arranque,
  input  logic [7:0] dado,
  input  logic [7:0] entrada,
  output logic [4:0] endereco,
  output logic [7:0] saida,
  output logic       saida_valida,
  output logic       parado
);

  typedef enum logic [1:0] {IDLE, FETCH, EXECUTE, HALT} state_t;

  state_t     state_reg, state_next;
  logic [4:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] acc_reg, acc_next;
  logic       z_reg, z_next;
  logic [7:0] saida_reg, saida_next;
  logic       valida_reg, valida_next;
  logic [7:0] rf_reg [8];

  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [2:0] op, rsel;
  logic [1:0] fsel;
  logic [4:0] alvo;
  logic [7:0] rd, soma, dif, dec;

  assign op   = ir_reg[7:5];
  assign rsel = ir_reg[4:2];
  assign fsel = ir_reg[1:0];
  assign alvo = ir_reg[4:0];
  assign rd   = rf_reg[rsel];
  assign soma = acc_reg + rd;
  assign dif  = acc_reg - rd;
  assign dec  = rd - 8'd1;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    acc_next    = acc_reg;
    z_next      = z_reg;
    saida_next  = saida_reg;
    valida_next = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = acc_reg;
    case (state_reg)
      IDLE: begin
        if (arranque) state_next = FETCH;
      end
      FETCH: begin
        ir_next    = dado;
        pc_next    = pc_reg + 5'd1;
        state_next = EXECUTE;
      end
      EXECUTE: begin
        state_next = FETCH;
        case (op)
          3'b000: begin
            case (fsel)
              2'b00: begin acc_next = rd;   z_next = (rd == 8'd0);   end
              2'b01: begin acc_next = soma; z_next = (soma == 8'd0); end
              2'b10: begin acc_next = dif;  z_next = (dif == 8'd0);  end
              default: begin rf_we = 1'b1; rf_wdata = acc_reg; end
            endcase
          end
          3'b001: begin
            rf_we    = 1'b1;
            rf_wdata = dec;
            z_next   = (dec == 8'd0);
          end
          3'b010: begin
            rf_we    = 1'b1;
            rf_wdata = entrada;
          end
          3'b011: begin
            saida_next  = rd;
            valida_next = 1'b1;
          end
          // Jumps overwrite the PC already incremented during FETCH
          3'b100: if (z_reg) pc_next = alvo;
          3'b101: pc_next = alvo;
          3'b110: if (!z_reg) pc_next = alvo;
          default: state_next = HALT;
        endcase
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= 5'd0;
      ir_reg     <= 8'd0;
      acc_reg    <= 8'd0;
      z_reg      <= 1'b0;
      saida_reg  <= 8'h00;
      valida_reg <= 1'b0;
      for (int i = 0; i < 8; i++) rf_reg[i] <= 8'd0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      acc_reg    <= acc_next;
      z_reg      <= z_next;
      saida_reg  <= saida_next;
      valida_reg <= valida_next;
      if (rf_we) rf_reg[rsel] <= rf_wdata;
    end
  end

  assign endereco     = pc_reg;
  assign saida        = saida_reg;
  assign saida_valida = valida_reg;
  assign parado       = (state_reg == HALT);

endmodule
